// File: rtl/pkg_config.sv
// Core-wide configuration: datapath width, ALU opcode encodings and the
// opcode legality helper shared by the ALU and its arbiter.
package pkg_config;

    localparam int DATA_WIDTH = 32;

    typedef logic [5:0] alu_op_t;

    localparam alu_op_t OP_ALU_ADD  = 6'h00;
    localparam alu_op_t OP_ALU_SUB  = 6'h01;
    localparam alu_op_t OP_ALU_SLL  = 6'h02;
    localparam alu_op_t OP_ALU_SLT  = 6'h03;
    localparam alu_op_t OP_ALU_SLTU = 6'h04;
    localparam alu_op_t OP_ALU_XOR  = 6'h05;
    localparam alu_op_t OP_ALU_SRL  = 6'h06;
    localparam alu_op_t OP_ALU_SRA  = 6'h07;
    localparam alu_op_t OP_ALU_OR   = 6'h08;
    localparam alu_op_t OP_ALU_AND  = 6'h09;

    function automatic logic alu_op_is_legal(alu_op_t op);
        case (op)
            OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
            OP_ALU_XOR, OP_ALU_SRL, OP_ALU_SRA, OP_ALU_OR, OP_ALU_AND:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_unit.sv
// RV32I integer ALU, purely combinational. Unknown opcodes produce 'x, so
// callers must screen the opcode before trusting the result.
module alu_unit
    import pkg_config::*;
(
    input  logic [5:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = b_i[SHW-1:0];

    always_comb begin
        case (op_i)
            OP_ALU_ADD:  result_o = a_i + b_i;
            OP_ALU_SUB:  result_o = a_i - b_i;
            OP_ALU_SLL:  result_o = a_i << shamt;
            OP_ALU_SLT:  result_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            OP_ALU_SLTU: result_o = DATA_WIDTH'(a_i < b_i);
            OP_ALU_XOR:  result_o = a_i ^ b_i;
            OP_ALU_SRL:  result_o = a_i >> shamt;
            OP_ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            OP_ALU_OR:   result_o = a_i | b_i;
            OP_ALU_AND:  result_o = a_i & b_i;
            default:     result_o = 'x;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: grants the first set request at or after the pointer,
// wrapping modulo N. Index is 0 when nothing is requested.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    // NOTE: every output gets a default before the scan so no path through
    // this block leaves a variable unassigned, which would infer a latch.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_unit among NUM_REQ valid/ready requesters with round-robin
// arbitration and a single registered, tagged response channel.
module alu_share_arbiter
    import pkg_config::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*6-1:0]          req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic [TAG_W-1:0]              rsp_tag_o,
    output logic                          rsp_err_o
);

    localparam int IDW = $clog2(NUM_REQ);

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]        rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0]      rsp_tag_q,   rsp_tag_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [IDW-1:0]        rr_ptr_q,    rr_ptr_d;

    logic                  grant_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDW-1:0]        gnt_idx;
    logic                  gnt_any;
    int                    sel;
    alu_op_t               sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [TAG_W-1:0]      sel_tag;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  op_legal;

    // Grants depend only on valids and the free slot, never on payloads.
    assign grant_en = !rst_i && (!rsp_valid_q || rsp_ready_i);

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i (req_valid_i & {NUM_REQ{grant_en}}),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready_o = gnt;

    assign sel     = int'(gnt_idx);
    assign sel_op  = req_op_i[6*sel +: 6];
    assign sel_a   = req_a_i[DATA_WIDTH*sel +: DATA_WIDTH];
    assign sel_b   = req_b_i[DATA_WIDTH*sel +: DATA_WIDTH];
    assign sel_tag = req_tag_i[TAG_W*sel +: TAG_W];

    alu_unit u_alu (
        .op_i     (sel_op),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .result_o (alu_result)
    );

    assign op_legal = alu_op_is_legal(sel_op);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            rsp_valid_d = 1'b1;
            // Mask the ALU's 'x for illegal ops so no X reaches the consumer.
            rsp_data_d  = op_legal ? alu_result : '0;
            rsp_err_d   = !op_legal;
            rsp_id_d    = gnt_idx;
            rsp_tag_d   = sel_tag;
            rr_ptr_d    = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one alu_unit instance between NUM_REQ independent requesters in the RV32I core, for example the EX stage and the branch/address-generation path. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle. The block registers the ALU result and returns it through a single valid/ready response channel tagged with the requester index. Illegal opcodes are caught here, because alu_unit drives 'x for unknown ops.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8.
TAG_W, 4, width of the opaque per-request tag, returned unchanged with the result.

Ports:
clk_i  input  1  core clock; all logic is on the rising edge.
rst_i  input  1  synchronous, active-high reset.
req_valid_i  input  NUM_REQ  per-requester request valid.
req_ready_o  output  NUM_REQ  per-requester request accepted this cycle.
req_op_i  input  NUM_REQ*6  packed alu_op per requester; slice i is [6*i+:6].
req_a_i  input  NUM_REQ*DATA_WIDTH  packed operand A per requester.
req_b_i  input  NUM_REQ*DATA_WIDTH  packed operand B per requester.
req_tag_i  input  NUM_REQ*TAG_W  packed tag per requester.
rsp_valid_o  output  1  response register holds a result.
rsp_ready_i  input  1  consumer accepts the response.
rsp_data_o  output  DATA_WIDTH  ALU result.
rsp_id_o  output  $clog2(NUM_REQ)  index of the requester that issued this result.
rsp_tag_o  output  TAG_W  tag of the issuing request.
rsp_err_o  output  1  the opcode was not a defined OP_ALU_* code.

Behaviour:
- Reset (rst_i=1 at a clock edge) forces:
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_tag_o=0, rsp_err_o=0.
  - rr_ptr=0.
  - Reset takes priority over every other event. An in-flight or unconsumed result is discarded.
  - req_ready_o is all-zero while rst_i=1.
- Output slot free: out_free = !rsp_valid_o || rsp_ready_i.
- Grant selection (combinational):
  - If out_free, the grant is the first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_o is one-hot on the granted index, otherwise all-zero.
  - req_ready_o[i] may depend combinationally on req_valid_i and rsp_ready_i.
  - req_ready_o[i] must not depend on requester i's own op, a, b or tag.
- Handshake on requester i: req_valid_i[i] && req_ready_o[i] at a clock edge. On that edge:
  - rsp_data_o <= the alu_unit result for requester i's op/a/b, or 0 if the op is illegal.
  - rsp_err_o <= illegal.
  - rsp_id_o <= i.
  - rsp_tag_o <= the tag.
  - rsp_valid_o <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- No handshake and rsp_ready_i=1: rsp_valid_o <= 0. The data fields keep their old values.
- rsp_valid_o=1 and rsp_ready_i=0: all rsp_* outputs are held stable and no grant is issued (backpressure).
- Simultaneous consume and accept (rsp_valid_o=1, rsp_ready_i=1, new handshake): the new result overwrites the old one and rsp_valid_o stays 1. Sustained throughput is 1 result per cycle.
- Latency is 1 cycle from the handshake edge to rsp_valid_o=1.
- Requester rules:
  - Once req_valid_i[i] is raised, the requester holds it and its op/a/b/tag stable until accepted.
  - This block does not check that rule.
- Legal opcodes are exactly the ten OP_ALU_* codes from pkg_config. Any other 6-bit value is illegal.
- Fairness: with k requesters continuously valid, each is granted at least once every k grants. No starvation under backpressure, because rr_ptr advances only on a grant.

Decomposition:
- OP_ALU_* codes and DATA_WIDTH stay in pkg_config.
- Add to pkg_config:
  - a function alu_op_is_legal(op), returning 1 for the ten defined codes;
  - a typedef alu_op_t (logic [5:0]).
- Sub-module rr_picker (parameter N):
  - inputs: req vector and pointer;
  - outputs: one-hot grant, grant index, any.
- alu_unit is instantiated once, unchanged. Its inputs are muxed from the granted requester; the index is 0 when there is no grant.

Test Plan:
- Single requester 0: ADD a=5, b=7, tag=3 → req_ready_o[0]=1 in the same cycle; next cycle rsp_valid_o=1, data=12, id=0, tag=3, err=0.
- Both requesters always valid with rsp_ready_i=1 from reset: 0: SUB 10-3, 1: SRA 0x80000000 by 4 → ids alternate 0,1,0,1… with data 7, 0xF8000000, 7, 0xF8000000…; one response every cycle.
- Backpressure: hold rsp_ready_i=0 for 3 cycles after a result 0x1234 → rsp_* are stable for those 3 cycles and req_ready_o=0; after rsp_ready_i=1, the next grant goes to the requester after the last-granted one.
- Illegal op 6'h3F from requester 1, tag=9 → rsp_err_o=1, rsp_data_o=0, rsp_id_o=1, rsp_tag_o=9; no X on any output.
- Signed/unsigned ops: SLT 0xFFFFFFFF<1 → 1; SLTU 0xFFFFFFFF<1 → 0; SLL 1 by 31 → 0x80000000.
- Reset mid-operation: assert rst_i while rsp_valid_o=1 and both requesters are valid → next cycle all rsp_* are 0 and rr_ptr=0; after release, the first grant goes to requester 0.
